dmem_access_ctrl: RTL and testbench

Sequencer for the MEM stage data-memory access. It watches the access request held in the EX/MEM pipeline register, drives a registered read or write request to the data-memory port, and stalls the pipeline until the memory answers with `dhit`. It also latches the returned load word and handles the terminal halt state. It sits between the EX/MEM pipeline register, the MEM/WB register enable, and the datapath-to-cache data port.

---
 rtl/dmem_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : MEM-stage data-memory access sequencer with stall and halt.
//            Optional access timeout enabled by defining DMEM_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dRENi,
    input  logic        dWENi,
    input  logic [31:0] ALUOut,
    input  logic [31:0] store,
    input  logic        halt,
    input  logic        dhit,
    input  logic [31:0] dload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] loadq,
    output logic        mm_en,
    output logic        halt_out,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       timeout;
    logic       start_req;

    assign start_req = (state == IDLE) && (next_state == REQ);

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;

    // Expiry loses to a dhit landing in the same cycle.
    assign timeout = (state == REQ) && !dhit && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmo_cnt <= 8'd0;
        end else if (start_req) begin
            tmo_cnt <= 8'd0;
        end else if ((state == REQ) && !dhit) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (halt) begin
                    next_state = HALT;
                end else if (dRENi || dWENi) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (dhit) begin
                    next_state = DONE;
                end else if (timeout) begin
                    next_state = HALT;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = HALT;
        endcase
    end

    always_comb begin
        mm_en    = 1'b1;
        halt_out = 1'b0;
        case (state)
            IDLE: mm_en = ~(dRENi | dWENi | halt);
            REQ:  mm_en = 1'b0;
            HALT: begin
                mm_en    = 1'b0;
                halt_out = 1'b1;
            end
            default: ;
        endcase
    end

    // Request registers: captured on IDLE->REQ, cleared on completion or expiry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            dmemaddr  <= 32'd0;
            dmemstore <= 32'd0;
            loadq     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        dmemaddr  <= ALUOut;
                        dmemstore <= store;
                        dmemWEN   <= dWENi;
                        dmemREN   <= dRENi & ~dWENi;
                    end
                end
                REQ: begin
                    if (dhit) begin
                        if (dmemREN) begin
                            loadq <= dload;
                        end
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                    end else if (timeout) begin
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Purpose  : Scoreboard bench for dmem_access_ctrl (define DMEM_TIMEOUT_EN
//            to also exercise the timeout path with TIMEOUT_CYCLES = 4).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_access_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        dRENi = 1'b0, dWENi = 1'b0, halt = 1'b0, dhit = 1'b0;
    logic [31:0] ALUOut = 32'd0, store = 32'd0, dload = 32'd0;
    logic        dmemREN, dmemWEN, mm_en, halt_out, err;
    logic [31:0] dmemaddr, dmemstore, loadq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] lq;
        int          hits;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_lq = 32'd0;

    int          obs_ren, obs_wen, obs_stall, obs_cycles;
    logic [31:0] obs_addr, obs_data;
    logic        obs_done;

    always #5 CLK = ~CLK;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .nRST(nRST), .dRENi(dRENi), .dWENi(dWENi),
        .ALUOut(ALUOut), .store(store), .halt(halt), .dhit(dhit),
        .dload(dload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .loadq(loadq),
        .mm_en(mm_en), .halt_out(halt_out), .err(err)
    );

    // Drives one access from an IDLE cycle (called at posedge+1), answers with
    // dhit on REQ cycle hit_at, and records what the DUT showed through DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input int hit_at,
                             input logic [31:0] dl);
        exp_t e;
        int   req;
        e.re = rd & ~wr;  e.we = wr;  e.addr = a;  e.data = d;  e.hits = hit_at;
        if (e.re) model_lq = dl;
        e.lq = model_lq;
        sb.push_back(e);
        dRENi = rd;  dWENi = wr;  ALUOut = a;  store = d;  halt = 1'b0;
        obs_ren = 0; obs_wen = 0; obs_stall = 0; obs_cycles = 0;
        obs_addr = 32'd0; obs_data = 32'd0; obs_done = 1'b0; req = 0;
        for (int c = 0; c < 40 && !obs_done; c++) begin
            dhit  = (dmemREN | dmemWEN) && (req + 1 == hit_at);
            dload = dl;
            if (dmemREN | dmemWEN) req++;
            @(negedge CLK);
            obs_cycles++;
            if (!mm_en) obs_stall++;
            if (dmemREN) obs_ren++;
            if (dmemWEN) obs_wen++;
            if (dmemREN | dmemWEN) begin
                obs_addr = dmemaddr;
                obs_data = dmemstore;
            end
            if (mm_en && obs_stall > 0) obs_done = 1'b1;
            @(posedge CLK); #1;
        end
        dRENi = 1'b0; dWENi = 1'b0; dhit = 1'b0; halt = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        dRENi = 1'b0; dWENi = 1'b0; dhit = 1'b0; halt = 1'b0;
        nRST = 1'b0;
        model_lq = 32'd0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++;
        if ({dmemREN, dmemWEN, halt_out, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ren/wen/halt/err=%b expected 0000",
                     {dmemREN, dmemWEN, halt_out, err});
        end
        n_tests++;
        if ({dmemaddr, dmemstore, loadq} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h store=%h loadq=%h expected all 0",
                     dmemaddr, dmemstore, loadq);
        end
        n_tests++;
        if (mm_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mm_en: got %b expected 1", mm_en);
        end
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_passthrough();
        int stalls = 0;
        int reqs   = 0;
        for (int i = 0; i < 4; i++) begin
            dhit = i[0];
            dload = 32'hFFFF_0000;
            @(negedge CLK);
            if (!mm_en) stalls++;
            if (dmemREN | dmemWEN) reqs++;
            @(posedge CLK); #1;
        end
        dhit = 1'b0;
        n_tests++;
        if (stalls !== 0 || reqs !== 0) begin
            n_fail++;
            $display("FAIL passthrough: got stalls=%0d reqs=%0d expected 0 and 0", stalls, reqs);
        end
        n_tests++;
        if (loadq !== model_lq) begin
            n_fail++;
            $display("FAIL stray_dhit_loadq: got %h expected %h", loadq, model_lq);
        end
    endtask

    task automatic test_load();
        exp_t e;
        do_access(1'b1, 1'b0, 32'h0000_0040, 32'd0, 3, 32'hDEAD_BEEF);
        e = sb.pop_front();
        n_tests++;
        if (obs_ren !== e.hits || obs_wen !== 0) begin
            n_fail++;
            $display("FAIL load_req_cycles: got ren=%0d wen=%0d expected ren=%0d wen=0",
                     obs_ren, obs_wen, e.hits);
        end
        n_tests++;
        if (obs_addr !== e.addr) begin
            n_fail++;
            $display("FAIL load_addr: got %h expected %h", obs_addr, e.addr);
        end
        n_tests++;
        if (obs_stall !== e.hits + 1 || !obs_done) begin
            n_fail++;
            $display("FAIL load_stall: got %0d stall cycles done=%b expected %0d done=1",
                     obs_stall, obs_done, e.hits + 1);
        end
        n_tests++;
        if (loadq !== e.lq) begin
            n_fail++;
            $display("FAIL load_data: got %h expected %h", loadq, e.lq);
        end
    endtask

    task automatic test_store();
        exp_t e;
        do_access(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 1, 32'h0BAD_0BAD);
        e = sb.pop_front();
        n_tests++;
        if (obs_wen !== e.hits || obs_ren !== 0) begin
            n_fail++;
            $display("FAIL store_req_cycles: got wen=%0d ren=%0d expected wen=%0d ren=0",
                     obs_wen, obs_ren, e.hits);
        end
        n_tests++;
        if (obs_addr !== e.addr || obs_data !== e.data) begin
            n_fail++;
            $display("FAIL store_capture: got addr=%h data=%h expected addr=%h data=%h",
                     obs_addr, obs_data, e.addr, e.data);
        end
        n_tests++;
        if (loadq !== e.lq) begin
            n_fail++;
            $display("FAIL store_loadq_kept: got %h expected %h", loadq, e.lq);
        end
        n_tests++;
        if (obs_stall !== 2 || obs_cycles !== 3) begin
            n_fail++;
            $display("FAIL store_latency: got stall=%0d cycles=%0d expected 2 and 3",
                     obs_stall, obs_cycles);
        end
    endtask

    task automatic test_conflict();
        exp_t e;
        do_access(1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 2, 32'h7777_7777);
        e = sb.pop_front();
        n_tests++;
        if (obs_ren !== 0 || obs_wen !== e.hits) begin
            n_fail++;
            $display("FAIL conflict_write_wins: got ren=%0d wen=%0d expected ren=0 wen=%0d",
                     obs_ren, obs_wen, e.hits);
        end
        n_tests++;
        if (loadq !== e.lq || obs_data !== e.data) begin
            n_fail++;
            $display("FAIL conflict_data: got loadq=%h data=%h expected loadq=%h data=%h",
                     loadq, obs_data, e.lq, e.data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic rd, wr;
        for (int i = 0; i < 6; i++) begin
            rd = i[0];
            wr = ~i[0] | (i == 5);
            do_access(rd, wr, 32'h1000 + 32'(i * 4), $urandom, $urandom_range(1, 3), $urandom);
            e = sb.pop_front();
            n_tests++;
            if (obs_ren !== (e.re ? e.hits : 0) || obs_wen !== (e.we ? e.hits : 0) ||
                obs_addr !== e.addr || (e.we && obs_data !== e.data) ||
                loadq !== e.lq || obs_cycles !== e.hits + 2) begin
                n_fail++;
                $display("FAIL b2b_%0d: got ren=%0d wen=%0d addr=%h loadq=%h cycles=%0d expected hits=%0d re=%b we=%b addr=%h loadq=%h",
                         i, obs_ren, obs_wen, obs_addr, loadq, obs_cycles,
                         e.hits, e.re, e.we, e.addr, e.lq);
            end
        end
    endtask

    task automatic test_reset_mid_req();
        dRENi = 1'b1; ALUOut = 32'h0000_0200;
        @(posedge CLK);
        @(posedge CLK); #2;
        nRST = 1'b0;
        model_lq = 32'd0;
        #1;
        n_tests++;
        if ({dmemREN, dmemWEN} !== 2'b00 || dmemaddr !== 32'd0 || loadq !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_req: got ren=%b wen=%b addr=%h loadq=%h expected all 0",
                     dmemREN, dmemWEN, dmemaddr, loadq);
        end
        dRENi = 1'b0; ALUOut = 32'd0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        dhit = 1'b1; dload = 32'h5555_AAAA;
        @(posedge CLK); #1;
        dhit = 1'b0;
        @(negedge CLK);
        n_tests++;
        if ({dmemREN, dmemWEN} !== 2'b00 || loadq !== model_lq || mm_en !== 1'b1) begin
            n_fail++;
            $display("FAIL late_dhit: got ren=%b wen=%b loadq=%h mm_en=%b expected 0 0 %h 1",
                     dmemREN, dmemWEN, loadq, mm_en, model_lq);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_halt();
        int bad = 0;
        halt = 1'b1; dRENi = 1'b1; ALUOut = 32'h0000_0300;
        @(negedge CLK);
        n_tests++;
        if (mm_en !== 1'b0 || halt_out !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_detect: got mm_en=%b halt_out=%b expected 0 0", mm_en, halt_out);
        end
        @(posedge CLK); #1;
        halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dhit = i[0];
            @(negedge CLK);
            if (halt_out !== 1'b1 || mm_en !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) bad++;
            @(posedge CLK); #1;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad);
        end
        apply_reset();
        @(negedge CLK);
        n_tests++;
        if (halt_out !== 1'b0 || mm_en !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_reset_exit: got halt_out=%b mm_en=%b expected 0 1", halt_out, mm_en);
        end
        @(posedge CLK); #1;
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        dRENi = 1'b1; ALUOut = 32'h0000_0400;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        n_tests++;
        if (err !== 1'b0 || dmemREN !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got err=%b ren=%b expected 0 1", err, dmemREN);
        end
        @(negedge CLK);
        n_tests++;
        if (err !== 1'b1 || halt_out !== 1'b1 || dmemREN !== 1'b0 || mm_en !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_expire: got err=%b halt_out=%b ren=%b mm_en=%b expected 1 1 0 0",
                     err, halt_out, dmemREN, mm_en);
        end
        apply_reset();
        do_access(1'b1, 1'b0, 32'h0000_0404, 32'd0, 4, 32'h0BAD_CAFE);
        e = sb.pop_front();
        n_tests++;
        if (err !== 1'b0 || obs_ren !== e.hits || loadq !== e.lq || halt_out !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_dhit_wins: got err=%b ren=%0d loadq=%h halt=%b expected 0 %0d %h 0",
                     err, obs_ren, loadq, halt_out, e.hits, e.lq);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_conflict();
        test_back_to_back();
        test_reset_mid_req();
        test_halt();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
